decode_scan_ctrl: RTL and testbench

Synchronous scan sequencer that drives the select inputs (A0–A2) and the enable inputs (G1, G2, G3) of the 74LS138 3-to-8 decoder stage directly downstream. It steps through the eight decoder outputs in ascending order with a programmable dwell time per channel and a blanking gap between channels, so two decoder outputs are never active together. Channels can be skipped with a mask. The block supports one-shot and continuous scanning and sits between the control logic and the decoder in scanned-display and strobe designs.

---
 rtl/decode_scan_pkg.sv | 16 +
 rtl/decode_scan_ctrl_if.sv | 28 ++
 rtl/scan_next_ch.sv | 29 ++
 rtl/decode_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_decode_scan_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_scan_pkg.sv
// Shared types and constants for the 74LS138 scan sequencer.
package decode_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int NUM_CH = 8;

    // Enable patterns ordered {G3, G2, G1}.
    localparam logic [2:0] G_ON  = 3'b001;
    localparam logic [2:0] G_OFF = 3'b110;

endpackage

// File: rtl/decode_scan_ctrl_if.sv
// Control/decoder bundle between the control logic (master) and the scan sequencer (slave).
interface decode_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    logic               i_start;
    logic               i_stop;
    logic               i_mode;
    logic [DWELL_W-1:0] i_dwell;
    logic [7:0]         i_mask;
    logic               o_a0;
    logic               o_a1;
    logic               o_a2;
    logic               o_g1;
    logic               o_g2;
    logic               o_g3;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_start, i_stop, i_mode, i_dwell, i_mask,
        input  o_a0, o_a1, o_a2, o_g1, o_g2, o_g3, o_busy, o_done
    );

    modport slave (
        input  i_start, i_stop, i_mode, i_dwell, i_mask,
        output o_a0, o_a1, o_a2, o_g1, o_g2, o_g3, o_busy, o_done
    );
endinterface

// File: rtl/scan_next_ch.sv
// Combinational channel finder: next set mask bit above the current channel and the lowest set bit.
module scan_next_ch
    import decode_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [2:0]        i_cur,
    output logic [2:0]        o_next,
    output logic [2:0]        o_low,
    output logic              o_found
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        o_next  = '0;
        o_low   = '0;
        o_found = 1'b0;
        // Walking downward leaves the lowest qualifying index as the final assignment.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_low = 3'(i);
                if (i > int'(i_cur)) begin
                    o_next  = 3'(i);
                    o_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decode_scan_ctrl.sv
// Scan sequencer driving A0-A2 and G1/G2/G3 of a 74LS138 with blanking between channels.
// Optional feature: define SCAN_MASK_EN to honour MASK; otherwise all 8 channels are scanned.
module decode_scan_ctrl
    import decode_scan_pkg::*;
#(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    decode_scan_ctrl_if.slave  bus
);

    localparam logic [3:0] BLANK_LD = 4'(BLANK_CYC);

    state_t             r_state;
    logic [2:0]         r_a;
    logic [2:0]         r_g;
    logic               r_busy;
    logic               r_done;
    logic               r_mode;
    logic [DWELL_W-1:0] r_dwell;
    logic [7:0]         r_mask;
    logic [3:0]         r_blank_cnt;
    logic [DWELL_W-1:0] r_dwell_cnt;

    logic [7:0]         w_mask_in;
    logic [7:0]         w_find_mask;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic [2:0]         w_next;
    logic [2:0]         w_low;
    logic               w_found;

`ifdef SCAN_MASK_EN
    assign w_mask_in = bus.i_mask;
`else
    assign w_mask_in = 8'hFF | bus.i_mask;
`endif

    // In IDLE the first channel comes from the mask being latched this cycle.
    assign w_find_mask = (r_state == IDLE) ? w_mask_in : r_mask;
    assign w_dwell_eff = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;

    scan_next_ch u_next (
        .i_mask  (w_find_mask),
        .i_cur   (r_a),
        .o_next  (w_next),
        .o_low   (w_low),
        .o_found (w_found)
    );

    always_ff @(posedge i_clk) begin
        // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
        if (i_rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_g         <= G_OFF;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mode      <= 1'b0;
            r_dwell     <= '0;
            r_mask      <= '0;
            r_blank_cnt <= '0;
            r_dwell_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.i_stop) begin
                r_state <= IDLE;
                r_g     <= G_OFF;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.i_start) begin
                            r_mode  <= bus.i_mode;
                            r_dwell <= bus.i_dwell;
                            r_mask  <= w_mask_in;
`ifdef SCAN_MASK_EN
                            if (w_mask_in == 8'h00) begin
                                r_done <= 1'b1;
                            end else
`endif
                            begin
                                r_a         <= w_low;
                                r_blank_cnt <= BLANK_LD;
                                r_busy      <= 1'b1;
                                r_state     <= BLANK;
                            end
                        end
                    end
                    BLANK: begin
                        if (r_blank_cnt <= 4'd1) begin
                            r_state     <= DRIVE;
                            r_g         <= G_ON;
                            r_dwell_cnt <= w_dwell_eff;
                        end else begin
                            r_blank_cnt <= r_blank_cnt - 4'd1;
                        end
                    end
                    DRIVE: begin
                        if (r_dwell_cnt <= DWELL_W'(1)) begin
                            r_g <= G_OFF;
                            if (w_found) begin
                                r_a         <= w_next;
                                r_blank_cnt <= BLANK_LD;
                                r_state     <= BLANK;
                            end else begin
                                r_done <= 1'b1;
                                if (r_mode) begin
                                    r_a         <= w_low;
                                    r_blank_cnt <= BLANK_LD;
                                    r_state     <= BLANK;
                                end else begin
                                    r_busy  <= 1'b0;
                                    r_state <= IDLE;
                                end
                            end
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_a0   = r_a[0];
    assign bus.o_a1   = r_a[1];
    assign bus.o_a2   = r_a[2];
    assign bus.o_g1   = r_g[0];
    assign bus.o_g2   = r_g[1];
    assign bus.o_g3   = r_g[2];
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;

endmodule

// File: tb/tb_decode_scan_ctrl.sv
// Self-checking bench for decode_scan_ctrl: per-cycle expected traces built from the scan rules.
module tb_decode_scan_ctrl;

    localparam int DWELL_W = 8;
    localparam int BLANK   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

    decode_scan_ctrl #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] a;
        logic       en;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [2:0] model_a = 3'd0;
    int         cnt_busy, cnt_g1, cnt_done;

    function automatic logic [7:0] eff_mask(input logic [7:0] m);
`ifdef SCAN_MASK_EN
        return m;
`else
        return 8'hFF | m;
`endif
    endfunction

    function automatic logic [2:0] obs_a();
        return {bus.o_a2, bus.o_a1, bus.o_a0};
    endfunction

    // Expected outputs, one entry per cycle after the START edge.
    task automatic build_model(input logic [7:0] m_in, input int d_in, input logic mode, input int passes);
        logic [7:0] m;
        int d;
        int low;
        logic pend;
        m    = eff_mask(m_in);
        d    = (d_in == 0) ? 1 : d_in;
        pend = 1'b0;
        low  = 0;
        exp_q.delete();
        if (m == 8'h00) begin
            exp_q.push_back('{model_a, 1'b0, 1'b0, 1'b1});
            return;
        end
        for (int i = 7; i >= 0; i--) if (m[i]) low = i;
        for (int p = 0; p < passes; p++) begin
            for (int ch = 0; ch < 8; ch++) begin
                if (m[ch]) begin
                    for (int b = 0; b < BLANK; b++) begin
                        exp_q.push_back('{3'(ch), 1'b0, 1'b1, pend});
                        pend = 1'b0;
                    end
                    for (int k = 0; k < d; k++) exp_q.push_back('{3'(ch), 1'b1, 1'b1, 1'b0});
                    model_a = 3'(ch);
                end
            end
            pend = 1'b1;
        end
        if (mode) begin
            model_a = 3'(low);
            exp_q.push_back('{model_a, 1'b0, 1'b1, 1'b1});
        end else begin
            exp_q.push_back('{model_a, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic play_and_compare(input string name);
        cnt_busy = 0; cnt_g1 = 0; cnt_done = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            cnt_busy += int'(bus.o_busy);
            cnt_g1   += int'(bus.o_g1);
            cnt_done += int'(bus.o_done);
            total++;
            if ({obs_a(), bus.o_g1, bus.o_g2, bus.o_g3, bus.o_busy, bus.o_done} !==
                {exp_q[i].a, exp_q[i].en, ~exp_q[i].en, ~exp_q[i].en, exp_q[i].busy, exp_q[i].done}) begin
                bad++;
                $display("FAIL %s cyc=%0d got a=%0d g1g2g3=%b%b%b busy=%b done=%b want a=%0d en=%b busy=%b done=%b",
                         name, i, obs_a(), bus.o_g1, bus.o_g2, bus.o_g3, bus.o_busy, bus.o_done,
                         exp_q[i].a, exp_q[i].en, exp_q[i].busy, exp_q[i].done);
            end
        end
    endtask

    // now=1 drives START in the current cycle (right after a negedge) instead of the next one.
    task automatic start_scan(input logic [7:0] m, input int d, input logic mode, input bit hold, input bit now);
        if (!now) @(negedge clk);
        bus.i_mask  = m;
        bus.i_dwell = DWELL_W'(d);
        bus.i_mode  = mode;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.i_start = 1'b0;
    endtask

    task automatic stop_now(input string name);
        bus.i_stop = 1'b1;
        @(posedge clk);
        #1;
        bus.i_stop  = 1'b0;
        bus.i_start = 1'b0;
        @(negedge clk);
        total++;
        if ({obs_a(), bus.o_g1, bus.o_g2, bus.o_g3, bus.o_busy, bus.o_done} !== {model_a, 5'b01100}) begin
            bad++;
            $display("FAIL %s got a=%0d g1g2g3=%b%b%b busy=%b done=%b want a=%0d g=011 busy=0 done=0",
                     name, obs_a(), bus.o_g1, bus.o_g2, bus.o_g3, bus.o_busy, bus.o_done, model_a);
        end
    endtask

    task automatic wait_drive_on(input logic [2:0] ch, input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.o_g1 && obs_a() == ch) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s timeout waiting for drive on channel %0d", name, ch);
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({obs_a(), bus.o_g1, bus.o_g2, bus.o_g3, bus.o_busy, bus.o_done} !== 8'b000_01100) begin
            bad++;
            $display("FAIL reset_init got a=%0d g=%b%b%b busy=%b done=%b want a=0 g=011 busy=0 done=0",
                     obs_a(), bus.o_g1, bus.o_g2, bus.o_g3, bus.o_busy, bus.o_done);
        end
        start_scan(8'hFF, 5, 1'b1, 1'b0, 1'b0);
        wait_drive_on(3'd3, "reset_wait", ok);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_a = 3'd0;
        total++;
        if ({obs_a(), bus.o_g1, bus.o_g2, bus.o_g3, bus.o_busy, bus.o_done} !== 8'b000_01100) begin
            bad++;
            $display("FAIL reset_mid got a=%0d g=%b%b%b busy=%b done=%b want a=0 g=011 busy=0 done=0",
                     obs_a(), bus.o_g1, bus.o_g2, bus.o_g3, bus.o_busy, bus.o_done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_g1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_after got busy=%b g1=%b want 0 0", bus.o_busy, bus.o_g1);
        end
    endtask

    task automatic test_oneshot_full();
        start_scan(8'hFF, 3, 1'b0, 1'b0, 1'b0);
        build_model(8'hFF, 3, 1'b0, 1);
        play_and_compare("oneshot_full");
        total++;
        if (cnt_busy !== 40 || cnt_g1 !== 24 || cnt_done !== 1) begin
            bad++;
            $display("FAIL oneshot_counts got busy=%0d g1=%0d done=%0d want 40 24 1", cnt_busy, cnt_g1, cnt_done);
        end
    endtask

    task automatic test_sparse_continuous();
        // START stays high and other inputs are scrambled: nothing may change mid-scan.
        start_scan(8'b1010_0100, 2, 1'b1, 1'b1, 1'b0);
        bus.i_mask  = 8'h0F;
        bus.i_dwell = 8'd7;
        bus.i_mode  = 1'b0;
        build_model(8'b1010_0100, 2, 1'b1, 3);
        play_and_compare("sparse_cont");
        total++;
        if (cnt_done !== 3) begin
            bad++;
            $display("FAIL sparse_done_count got %0d want 3", cnt_done);
        end
        stop_now("sparse_stop");
    endtask

    task automatic test_empty_zero_dwell();
        start_scan(8'h00, 3, 1'b0, 1'b0, 1'b0);
        build_model(8'h00, 3, 1'b0, 1);
        play_and_compare("empty_mask");
        start_scan(8'h01, 0, 1'b0, 1'b0, 1'b0);
        build_model(8'h01, 0, 1'b0, 1);
        play_and_compare("zero_dwell");
    endtask

    task automatic test_stop();
        bit ok;
        start_scan(8'hFF, 4, 1'b1, 1'b0, 1'b0);
        wait_drive_on(3'd4, "stop_wait", ok);
        model_a = 3'd4;
        stop_now("stop_mid");
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            total++;
            if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || obs_a() !== 3'd4) begin
                bad++;
                $display("FAIL stop_hold cyc=%0d got done=%b busy=%b a=%0d want 0 0 4", n, bus.o_done, bus.o_busy, obs_a());
            end
        end
        bus.i_mask  = 8'hFF;
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            total++;
            if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_g1 !== 1'b0) begin
                bad++;
                $display("FAIL stop_start cyc=%0d got busy=%b done=%b g1=%b want 0 0 0", n, bus.o_busy, bus.o_done, bus.o_g1);
            end
        end
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
    endtask

`ifndef SCAN_MASK_EN
    task automatic test_mask_ignored();
        start_scan(8'h00, 2, 1'b0, 1'b0, 1'b0);
        build_model(8'hFF, 2, 1'b0, 1);
        play_and_compare("mask_ignored");
        total++;
        if (cnt_g1 !== 16) begin
            bad++;
            $display("FAIL mask_ignored_g1 got %0d want 16", cnt_g1);
        end
    endtask
`endif

    task automatic test_back_to_back();
        start_scan(8'h81, 2, 1'b0, 1'b0, 1'b0);
        build_model(8'h81, 2, 1'b0, 1);
        play_and_compare("b2b_first");
        start_scan(8'h18, 1, 1'b0, 1'b0, 1'b1);
        build_model(8'h18, 1, 1'b0, 1);
        play_and_compare("b2b_second");
    endtask

    task automatic test_random();
        logic [7:0] m;
        int d;
        logic mode;
        for (int it = 0; it < 8; it++) begin
            m    = 8'($urandom);
            d    = $urandom_range(0, 4);
            mode = 1'($urandom_range(0, 1));
            start_scan(m, d, mode, 1'b0, 1'b0);
            build_model(m, d, mode, mode ? 2 : 1);
            play_and_compare($sformatf("random%0d", it));
            if (mode && eff_mask(m) != 8'h00) stop_now($sformatf("random%0d_stop", it));
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_mode  = 1'b0;
        bus.i_dwell = '0;
        bus.i_mask  = '0;
        test_reset();
        test_oneshot_full();
        test_sparse_continuous();
        test_empty_zero_dwell();
        test_stop();
`ifndef SCAN_MASK_EN
        test_mask_ignored();
`endif
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
